fetch_queue: RTL

Parametrised instruction fetch stage that succeeds the combinational `program_counter`. It owns the PC register and issues in-order instruction-memory requests with valid/ready handshaking. It buffers returned words with their PCs in a DEPTH-entry queue for the decoder, and handles branch redirects and halt. It sits between instruction memory and `decoder`.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int FETCH_XLEN  = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests under
// a credit limit and buffers returned words with their PCs for the decoder.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_keep;
    logic            halt_entry;
    logic            flush;
    logic [XLEN-1:0] tag_pc;
    logic [CW-1:0]   tag_count;
    logic            tag_empty;
    logic            tag_full;
    logic            q_empty;
    logic            q_full;
    entry_t          push_entry;
    entry_t          head_entry;

    assign in_use           = {1'b0, count} + {1'b0, outstanding};
    assign req_addr         = pc;
    assign req_fire         = req_valid && req_ready;
    assign rsp_accept       = rsp_valid && (outstanding != '0);
    assign rsp_keep         = rsp_accept && (drop == '0);
    assign halt_entry       = (state == RUN) && halt && !redirect;
    assign flush            = redirect || halt_entry;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect)         state_next = RUN;
        else if (halt_entry)  state_next = HALT;
    end

    always_comb begin
        req_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            RUN:     req_valid = (in_use < (CW+1)'(DEPTH));
            HALT:    halted    = 1'b1;
            default: halted    = 1'b0;
        endcase
    end

    // Every request still in flight at a flush becomes stale; stale responses
    // always precede fresh ones, so a single countdown discards them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect)      pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (req_fire) pc <= pc + XLEN'(INSTR_BYTES);
            if (flush)                          drop <= outstanding_next;
            else if (rsp_accept && drop != '0)  drop <= drop - CW'(1);
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    assign push_entry = '{instr: rsp_data, pc: tag_pc};

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (out_valid && out_ready),
        .pop_data  (head_entry),
        .count     (count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign out_valid = !q_empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

    rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outstanding != '0));
    tags_track_live_requests: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == outstanding - drop);
    tag_present_for_kept_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !tag_empty);
    tag_room_on_fire: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> !tag_full);
    queue_room_on_push: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && q_full && !(out_valid && out_ready)));

endmodule
